// File: rtl/riot_bus_arbiter.sv
// Shares the RIOT register/RAM bus between the CPU (always first) and a host
// debug port. Host accesses use only ce slots in which the CPU leaves the RIOT idle.
module riot_bus_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       cpu_sel,
  input  logic [6:0] cpu_addr,
  input  logic       cpu_rs_n,
  input  logic       cpu_rw_n,
  input  logic [7:0] cpu_din,
  input  logic       host_req,
  input  logic       host_we,
  input  logic       host_rs_n,
  input  logic [6:0] host_addr,
  input  logic [7:0] host_din,
  output logic       host_ack,
  output logic       host_err,
  output logic [7:0] host_dout,
  output logic       host_busy,
  output logic       riot_ce,
  output logic       riot_sel,
  output logic [6:0] riot_addr,
  output logic       riot_rs_n,
  output logic       riot_rw_n,
  output logic [7:0] riot_din,
  input  logic [7:0] riot_dout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] cnt;
  logic          err_q;
  logic          we_q;
  logic          rs_n_q;
  logic [6:0]    addr_q;
  logic [7:0]    din_q;
  logic [7:0]    dout_q;
  logic          host_slot;

  assign host_slot = (state == S_WAIT) && ce && !cpu_sel;

  // The RIOT always sees exactly the CPU's ce stream; host only borrows idle slots.
  assign riot_ce   = ce;
  assign riot_sel  = host_slot ? 1'b1   : cpu_sel;
  assign riot_addr = host_slot ? addr_q : cpu_addr;
  assign riot_rs_n = host_slot ? rs_n_q : cpu_rs_n;
  assign riot_rw_n = host_slot ? ~we_q  : cpu_rw_n;
  assign riot_din  = host_slot ? din_q  : cpu_din;

  assign host_ack  = (state == S_DONE);
  assign host_err  = (state == S_DONE) && err_q;
  assign host_busy = (state != S_IDLE);
  assign host_dout = dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;
      rs_n_q <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      dout_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host_req) begin
            we_q   <= host_we;
            rs_n_q <= host_rs_n;
            addr_q <= host_addr;
            din_q  <= host_din;
            cnt    <= '0;
            err_q  <= 1'b0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // host_slot and a CPU-selected ce are mutually exclusive, so a free
          // slot can never lose to the timeout.
          if (host_slot) begin
            state <= we_q ? S_DONE : S_ACCESS;
          end else if (ce && cpu_sel) begin
            if (cnt == TW'(TIMEOUT - 1)) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_ACCESS: begin
          // RIOT registered d_out at the end of the slot; a CPU read now lands after this edge.
          dout_q <= riot_dout;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riot_bus_arbiter.sv
// Directed bench for riot_bus_arbiter with a small behavioural RIOT register/RAM model.
module tb_riot_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       cpu_sel;
  logic [6:0] cpu_addr;
  logic       cpu_rs_n;
  logic       cpu_rw_n;
  logic [7:0] cpu_din;
  logic       host_req;
  logic       host_req2;
  logic       host_we;
  logic       host_rs_n;
  logic [6:0] host_addr;
  logic [7:0] host_din;
  logic       host_ack, host_err, host_busy;
  logic [7:0] host_dout;
  logic       riot_ce, riot_sel, riot_rs_n, riot_rw_n;
  logic [6:0] riot_addr;
  logic [7:0] riot_din;
  logic [7:0] riot_dout;

  logic       ack2, err2, busy2;
  logic [7:0] dout2;
  logic       rce2, rsel2, rrs2, rrw2;
  logic [6:0] raddr2;
  logic [7:0] rdin2;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [128];
  logic [7:0] io  [128];

  always #5 clk = ~clk;

  riot_bus_arbiter dut (
    .clk(clk), .reset(reset), .ce(ce), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
    .cpu_rs_n(cpu_rs_n), .cpu_rw_n(cpu_rw_n), .cpu_din(cpu_din),
    .host_req(host_req), .host_we(host_we), .host_rs_n(host_rs_n),
    .host_addr(host_addr), .host_din(host_din),
    .host_ack(host_ack), .host_err(host_err), .host_dout(host_dout), .host_busy(host_busy),
    .riot_ce(riot_ce), .riot_sel(riot_sel), .riot_addr(riot_addr), .riot_rs_n(riot_rs_n),
    .riot_rw_n(riot_rw_n), .riot_din(riot_din), .riot_dout(riot_dout)
  );

  riot_bus_arbiter #(.TIMEOUT(4), .TW(3)) dut_to (
    .clk(clk), .reset(reset), .ce(ce), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
    .cpu_rs_n(cpu_rs_n), .cpu_rw_n(cpu_rw_n), .cpu_din(cpu_din),
    .host_req(host_req2), .host_we(host_we), .host_rs_n(host_rs_n),
    .host_addr(host_addr), .host_din(host_din),
    .host_ack(ack2), .host_err(err2), .host_dout(dout2), .host_busy(busy2),
    .riot_ce(rce2), .riot_sel(rsel2), .riot_addr(raddr2), .riot_rs_n(rrs2),
    .riot_rw_n(rrw2), .riot_din(rdin2), .riot_dout(8'h00)
  );

  // RIOT stand-in: writes on a selected ce, read data registered one clk later
  initial begin
    for (int i = 0; i < 128; i++) begin
      ram[i] = 8'h00;
      io[i]  = 8'h00;
    end
    riot_dout = 8'h00;
  end

  always @(posedge clk) begin
    if (riot_ce && riot_sel) begin
      if (!riot_rw_n) begin
        if (!riot_rs_n) ram[riot_addr] <= riot_din;
        else            io[riot_addr]  <= riot_din;
      end else begin
        riot_dout <= !riot_rs_n ? ram[riot_addr] : io[riot_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    ce = 1'b0; cpu_sel = 1'b0; cpu_addr = 7'h00; cpu_rs_n = 1'b0;
    cpu_rw_n = 1'b1; cpu_din = 8'h00;
  endtask

  task automatic host_set(input logic we, input logic rs_n, input logic [6:0] a,
                          input logic [7:0] d);
    host_req = 1'b1; host_we = we; host_rs_n = rs_n; host_addr = a; host_din = d;
  endtask

  initial begin
    reset = 1'b1; host_req = 1'b0; host_req2 = 1'b0;
    host_we = 1'b0; host_rs_n = 1'b0; host_addr = 7'h00; host_din = 8'h00;
    idle_bus();
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_ack", {31'd0, host_ack}, 32'd0);
    chk("rst_err", {31'd0, host_err}, 32'd0);
    chk("rst_busy", {31'd0, host_busy}, 32'd0);
    chk("rst_dout", {24'd0, host_dout}, 32'h00);

    // 1: host write RAM 10 = A5, ce every third clk
    host_set(1'b1, 1'b0, 7'h10, 8'hA5);
    step();
    chk("t1_busy", {31'd0, host_busy}, 32'd1);
    host_din = 8'h3C; host_addr = 7'h55;
    step();
    chk("t1_hold", {31'd0, host_ack}, 32'd0);
    step();
    ce = 1'b1; #1;
    chk("t1_sel", {31'd0, riot_sel}, 32'd1);
    chk("t1_rw", {31'd0, riot_rw_n}, 32'd0);
    chk("t1_addr", {25'd0, riot_addr}, 32'h10);
    chk("t1_din", {24'd0, riot_din}, 32'hA5);
    step();
    ce = 1'b0; host_req = 1'b0; #1;
    chk("t1_ack", {31'd0, host_ack}, 32'd1);
    chk("t1_err", {31'd0, host_err}, 32'd0);
    chk("t1_busy_ack", {31'd0, host_busy}, 32'd1);
    step();
    chk("t1_ack_pulse", {31'd0, host_ack}, 32'd0);
    chk("t1_idle", {31'd0, host_busy}, 32'd0);
    ce = 1'b1; cpu_sel = 1'b1; cpu_addr = 7'h10; cpu_rw_n = 1'b1;
    step();
    idle_bus(); #1;
    chk("t1_cpu_rd", {24'd0, riot_dout}, 32'hA5);

    // 2: host read RAM 10
    host_set(1'b0, 1'b0, 7'h10, 8'h00);
    step();
    ce = 1'b1; #1;
    chk("t2_rw", {31'd0, riot_rw_n}, 32'd1);
    chk("t2_sel", {31'd0, riot_sel}, 32'd1);
    step();
    ce = 1'b0; #1;
    chk("t2_no_ack", {31'd0, host_ack}, 32'd0);
    step();
    host_req = 1'b0; #1;
    chk("t2_ack", {31'd0, host_ack}, 32'd1);
    chk("t2_dout", {24'd0, host_dout}, 32'hA5);
    step();

    // 3: CPU holds the RIOT for 5 ce, host gets the 6th
    host_set(1'b1, 1'b0, 7'h20, 8'h5A);
    step();
    for (int i = 0; i < 5; i++) begin
      ce = 1'b1; cpu_sel = 1'b1; cpu_addr = 7'h30; cpu_rw_n = 1'b0; cpu_din = 8'(i + 1);
      #1;
      chk("t3_cpu_addr", {25'd0, riot_addr}, 32'h30);
      chk("t3_cpu_din", {24'd0, riot_din}, 32'(i + 1));
      chk("t3_cpu_rw", {31'd0, riot_rw_n}, 32'd0);
      chk("t3_ce", {31'd0, riot_ce}, 32'd1);
      step();
      idle_bus(); #1;
      chk("t3_no_slot", {31'd0, riot_sel}, 32'd0);
      chk("t3_wait", {31'd0, host_busy & ~host_ack}, 32'd1);
      step();
    end
    ce = 1'b1; #1;
    chk("t3_host_addr", {25'd0, riot_addr}, 32'h20);
    chk("t3_host_din", {24'd0, riot_din}, 32'h5A);
    step();
    ce = 1'b0; host_req = 1'b0; #1;
    chk("t3_ack", {31'd0, host_ack}, 32'd1);
    chk("t3_err", {31'd0, host_err}, 32'd0);
    chk("t3_ram20", {24'd0, ram[7'h20]}, 32'h5A);
    chk("t3_ram30", {24'd0, ram[7'h30]}, 32'h05);
    step();

    // 4: TIMEOUT=4 instance with CPU owning every ce
    host_set(1'b1, 1'b0, 7'h40, 8'hFF);
    host_req = 1'b0; host_req2 = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1; cpu_sel = 1'b1; cpu_addr = 7'h41; cpu_rw_n = 1'b1; #1;
      chk("t4_pass", {25'd0, raddr2}, 32'h41);
      chk("t4_pass_rw", {31'd0, rrw2}, 32'd1);
      step();
      idle_bus(); #1;
      if (i < 3) chk("t4_no_ack", {31'd0, ack2}, 32'd0);
    end
    host_req2 = 1'b0;
    chk("t4_ack", {31'd0, ack2}, 32'd1);
    chk("t4_err", {31'd0, err2}, 32'd1);
    chk("t4_ram40", {24'd0, ram[7'h40]}, 32'h00);
    step();
    chk("t4_idle", {31'd0, busy2}, 32'd0);

    // 5: host write TIM1T (I/O 14) = 03, then host read-back through I/O space
    host_set(1'b1, 1'b1, 7'h14, 8'h03);
    step();
    ce = 1'b1; #1;
    chk("t5_rs", {31'd0, riot_rs_n}, 32'd1);
    step();
    ce = 1'b0; host_req = 1'b0; #1;
    chk("t5_ack", {31'd0, host_ack}, 32'd1);
    step();
    host_set(1'b0, 1'b1, 7'h14, 8'h00);
    step();
    ce = 1'b1; step();
    ce = 1'b0; step();
    host_req = 1'b0; #1;
    chk("t5_rd", {24'd0, host_dout}, 32'h03);
    step();

    // 6a: reset while in ACCESS
    host_set(1'b0, 1'b0, 7'h10, 8'h00);
    step();
    ce = 1'b1; step();
    ce = 1'b0; host_req = 1'b0; reset = 1'b1;
    step();
    chk("t6a_busy", {31'd0, host_busy}, 32'd0);
    chk("t6a_ack", {31'd0, host_ack}, 32'd0);
    chk("t6a_dout", {24'd0, host_dout}, 32'h00);
    reset = 1'b0;
    step();
    chk("t6a_no_ack", {31'd0, host_ack}, 32'd0);

    // 6b: reset while in WAIT
    host_set(1'b1, 1'b0, 7'h11, 8'h77);
    step();
    chk("t6b_in_wait", {31'd0, host_busy}, 32'd1);
    host_req = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6b_busy", {31'd0, host_busy}, 32'd0);
    ce = 1'b1; #1;
    chk("t6b_no_slot", {31'd0, riot_sel}, 32'd0);
    step();
    ce = 1'b0; #1;
    chk("t6b_ack", {31'd0, host_ack}, 32'd0);
    chk("t6b_ram11", {24'd0, ram[7'h11]}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riot_bus_arbiter.md
Name: riot_bus_arbiter

Overview:
- Shares the single M6532 RIOT register/RAM bus between the 6502 CPU and a host-side debug/savestate port.
- The CPU always has priority and is never stalled.
- Host accesses are inserted only into CPU-enable slots in which the CPU does not select the RIOT. The RIOT therefore sees exactly one ce per CPU cycle, and timer/prescaler timing is unchanged.
- Sits between the CPU address decode and the RIOT instance in the console top level.

Parameters:
- TIMEOUT, 1023: number of ce slots a pending host request may wait before it is aborted with an error.
- TW, 10: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, the same clock as the RIOT.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  CPU clock-enable strobe; passed unchanged to the RIOT.
- cpu_sel  in  1  CPU decode selects the RIOT (CS1 & ~CS2_n) in this slot.
- cpu_addr  in  7  CPU address[6:0].
- cpu_rs_n  in  1  CPU RAM select, active low.
- cpu_rw_n  in  1  CPU read/write: 1 = read, 0 = write.
- cpu_din  in  8  CPU write data.
- host_req  in  1  host request; level, held until host_ack.
- host_we  in  1  1 = write; sampled with host_req.
- host_rs_n  in  1  0 = RAM, 1 = I/O/timer; sampled with host_req.
- host_addr  in  7  host address; sampled with host_req.
- host_din  in  8  host write data; sampled with host_req.
- host_ack  out  1  one-cycle completion pulse.
- host_err  out  1  valid with host_ack; 1 = timed out, access not performed.
- host_dout  out  8  read data; valid from host_ack until the next ack.
- host_busy  out  1  high from request acceptance until the ack cycle, inclusive.
- riot_ce  out  1  equals ce.
- riot_sel  out  1  drives RIOT CS1; RIOT CS2_n is tied low at the top level.
- riot_addr  out  7  to RIOT addr.
- riot_rs_n  out  1  to RIOT RS_n.
- riot_rw_n  out  1  to RIOT RW_n.
- riot_din  out  8  to RIOT d_in.
- riot_dout  in  8  RIOT d_out; registered inside the RIOT, valid one clk after a selected read cycle.

Behaviour:

Reset:
- State = IDLE.
- host_ack = 0, host_err = 0, host_busy = 0, host_dout = 8'h00, timeout counter = 0.

Bus mux (combinational):
- host_slot = (state == WAIT) & ce & ~cpu_sel.
- When host_slot = 1: the RIOT outputs carry the latched host request, with riot_sel = 1 and riot_rw_n = ~we.
- Otherwise the RIOT outputs pass the CPU signals through unchanged (riot_sel = cpu_sel).
- riot_ce = ce always. No extra ce is generated and none is suppressed.

FSM:
- IDLE
  - host_req = 1 → latch we/rs_n/addr/din, clear the counter, go to WAIT.
  - host_busy rises in the cycle after host_req is sampled.
- WAIT
  - host_slot → go to ACCESS for a read, or DONE for a write. The RIOT performs the write at this edge.
  - ce & cpu_sel → counter + 1. If counter == TIMEOUT-1 → go to DONE with err = 1.
  - Cycles without ce → hold.
- ACCESS (one cycle; read only)
  - The RIOT registers d_out at the end of the host_slot cycle.
  - At the end of the ACCESS cycle, host_dout <= riot_dout, then go to DONE.
  - A CPU read of the RIOT in the ACCESS cycle overwrites d_out only after this edge, so the captured value is unaffected.
- DONE
  - host_ack = 1 for one cycle; host_err is valid in the same cycle.
  - Go to IDLE.
  - host_req must be deasserted by the cycle after the ack. If it is still high in IDLE, it is treated as a new request.

Latency:
- Write: ack 1 clk after the slot.
- Read: ack 2 clk after the slot.
- Minimum request→ack: write 2 clk, read 3 clk (request sampled into WAIT, slot available immediately).

Side effects:
- Host accesses have full RIOT semantics: timer writes, reads that clear interrupt flags, and DDR/port writes all take effect.
- No side-effect-free peek exists.

Simultaneous events:
- CPU select in the same ce as a pending host request → the CPU wins and the host keeps waiting.
- Timeout and a free slot in the same ce → the slot wins; the access is performed with err = 0.

Other:
- Reset asserted mid-operation → abort immediately to IDLE; no ack is issued; host_dout is cleared.
- Request fields changed while busy are ignored; the latched copy is used.

Test Plan:
1. Host write RAM addr 7'h10 = 8'hA5 with cpu_sel = 0, ce every 3 clk → ack 1 clk after the first ce, err = 0; a CPU read of 7'h10 then returns 8'hA5.
2. Host read of RAM 7'h10 → host_dout = 8'hA5 on the ack, which arrives 2 clk after the slot; riot_rw_n = 1 in the slot cycle.
3. cpu_sel = 1 for 5 consecutive ce while a host request is pending → no host signals reach the RIOT, and CPU accesses pass through unchanged. On the 6th ce with cpu_sel = 0 the host access is performed. The timer decrements exactly once per ce throughout.
4. TIMEOUT = 4, cpu_sel held at 1 → ack with err = 1 after the 4th CPU-selected ce; RIOT RAM is unmodified.
5. Host write to 7'h14 (TIM1T) with rs_n = 1 and din = 8'h03 → the RIOT timer reads 8'h03, then decrements on subsequent ce; interrupt[7] is cleared.
6. Reset asserted in WAIT and in ACCESS → the next cycle shows IDLE, host_busy = 0, host_ack never pulses, host_dout = 8'h00.
